// File: rtl/seq_match_pkg.sv
// Shared types and sizing helpers for the stream pattern detector.
package seq_match_pkg;

  typedef enum logic {
    FILLING = 1'b0,
    ARMED   = 1'b1
  } state_t;

  localparam int DEF_DEPTH = 4;

  // Slot index width; a single-slot pattern still needs a 1-bit index port.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Fill counter must represent 0..depth inclusive.
  function automatic int fill_w(input int depth);
    return (depth > 1) ? $clog2(depth + 1) : 1;
  endfunction

  localparam int IDX_W = idx_w(DEF_DEPTH);

endpackage

// File: rtl/seq_match_if.sv
// Stream, configuration and status bundle between a stream source and the detector.
interface seq_match_if
  import seq_match_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int IW = idx_w(DEPTH);

  logic             clear;
  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic [WIDTH-1:0] cfg_pattern;
  logic [WIDTH-1:0] cfg_mask;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             armed;

  modport master (
    output clear, cfg_we, cfg_idx, cfg_pattern, cfg_mask, in_valid, in_data,
    input  match, match_count, armed
  );

  modport slave (
    input  clear, cfg_we, cfg_idx, cfg_pattern, cfg_mask, in_valid, in_data,
    output match, match_count, armed
  );
endinterface

// File: rtl/seq_match_det_word_cmp.sv
// Masked single-word equality: a mask bit of 0 makes that bit a don't-care.
module word_cmp_masked #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] mask,
  output logic             eq
);
  assign eq = (((a ^ b) & mask) == '0);
endmodule

// File: rtl/seq_match_det.sv
// Sliding-window masked pattern detector: registered 1-cycle match pulse one cycle
// after the completing word, saturating match count; no backpressure (in_valid only).
module seq_match_det
  import seq_match_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic      clk,
  input  logic      reset,
  seq_match_if.slave bus
);
  localparam int                FILL_W  = fill_w(DEPTH);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  win     [DEPTH];
  logic [WIDTH-1:0]  win_nxt [DEPTH];
  logic [WIDTH-1:0]  pat     [DEPTH];
  logic [WIDTH-1:0]  msk     [DEPTH];
  logic [DEPTH-1:0]  eq;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_nxt;
  logic              hit;
  logic              match_q;
  logic [CNT_W-1:0]  cnt_q;
  state_t            state;

  // Compare against the post-shift window so the completing word itself is judged.
  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      win_nxt[k] = win[k+1];
    end
    win_nxt[DEPTH-1] = bus.in_data;
  end

  assign fill_nxt = (fill == FULL) ? fill : fill + 1'b1;

  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    word_cmp_masked #(.WIDTH(WIDTH)) u_cmp (
      .a    (win_nxt[k]),
      .b    (pat[k]),
      .mask (msk[k]),
      .eq   (eq[k])
    );
  end

  assign hit = bus.in_valid && (&eq) && (fill_nxt == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        win[k] <= '0;
        pat[k] <= '0;
        msk[k] <= '1;
      end
      fill    <= '0;
      state   <= FILLING;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      match_q <= 1'b0;
      // Pattern updates land at the edge, so a same-cycle word still sees the old slot.
      if (bus.cfg_we && (int'(bus.cfg_idx) < DEPTH)) begin
        pat[bus.cfg_idx] <= bus.cfg_pattern;
        msk[bus.cfg_idx] <= bus.cfg_mask;
      end
      if (bus.clear) begin
        fill  <= '0;
        state <= FILLING;
        cnt_q <= '0;
      end else if (bus.in_valid) begin
        win <= win_nxt;
        if (hit) begin
          match_q <= 1'b1;
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end
        // Non-overlapping mode restarts the fill so the next match needs DEPTH fresh words.
        if (hit && (OVERLAP == 0)) begin
          fill  <= '0;
          state <= FILLING;
        end else begin
          fill  <= fill_nxt;
          state <= (fill_nxt == FULL) ? ARMED : FILLING;
        end
      end
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.armed       = (state == ARMED);

endmodule

// File: tb/tb_seq_match_det.sv
// Directed bench: one shared stimulus drives three detector variants; a negedge
// monitor pops queued expectations (match, count, armed) and compares.
module tb_seq_match_det;

  logic       clk = 1'b0;
  logic       s_rst, s_clr, s_we, s_vld;
  logic [1:0] s_idx;
  logic [7:0] s_pat, s_msk, s_dat;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;

  typedef struct {
    int due;
    int sel;
    bit m;
    int c;
    bit a;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_match_if #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) if0 ();
  seq_match_if #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) if1 ();
  seq_match_if #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) if2 ();

  assign if0.clear = s_clr;  assign if0.cfg_we = s_we;  assign if0.cfg_idx = s_idx;
  assign if0.cfg_pattern = s_pat;  assign if0.cfg_mask = s_msk;
  assign if0.in_valid = s_vld;  assign if0.in_data = s_dat;
  assign if1.clear = s_clr;  assign if1.cfg_we = s_we;  assign if1.cfg_idx = s_idx;
  assign if1.cfg_pattern = s_pat;  assign if1.cfg_mask = s_msk;
  assign if1.in_valid = s_vld;  assign if1.in_data = s_dat;
  assign if2.clear = s_clr;  assign if2.cfg_we = s_we;  assign if2.cfg_idx = s_idx;
  assign if2.cfg_pattern = s_pat;  assign if2.cfg_mask = s_msk;
  assign if2.in_valid = s_vld;  assign if2.in_data = s_dat;

  seq_match_det #(.WIDTH(8), .DEPTH(4), .CNT_W(8), .OVERLAP(1)) d0 (.clk(clk), .reset(s_rst), .bus(if0));
  seq_match_det #(.WIDTH(8), .DEPTH(4), .CNT_W(8), .OVERLAP(0)) d1 (.clk(clk), .reset(s_rst), .bus(if1));
  seq_match_det #(.WIDTH(8), .DEPTH(4), .CNT_W(2), .OVERLAP(1)) d2 (.clk(clk), .reset(s_rst), .bus(if2));

  // Monitor: outputs settle after the posedge; compare everything due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      bit   am, aa;
      int   ac;
      e = sb.pop_front();
      case (e.sel)
        0:       begin am = if0.match; ac = int'(if0.match_count); aa = if0.armed; end
        1:       begin am = if1.match; ac = int'(if1.match_count); aa = if1.armed; end
        default: begin am = if2.match; ac = int'(if2.match_count); aa = if2.armed; end
      endcase
      n_vec++;
      if (e.due != cyc || am != e.m || ac != e.c || aa != e.a) begin
        n_bad++;
        $display("FAIL vec%0d dut%0d cyc%0d: got match=%0b count=%0d armed=%0b, want match=%0b count=%0d armed=%0b (due %0d)",
                 n_vec, e.sel, cyc, am, ac, aa, e.m, e.c, e.a, e.due);
      end
    end
  end

  task automatic exp(input int sel, input bit m, input int c, input bit a);
    exp_t e;
    e.due = cyc + 1; e.sel = sel; e.m = m; e.c = c; e.a = a;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    s_rst = 1'b0; s_clr = 1'b0; s_we = 1'b0; s_vld = 1'b0;
  endtask

  task automatic wd(input logic [7:0] d);
    s_vld = 1'b1; s_dat = d;
  endtask

  task automatic cfg_set(input logic [1:0] idx, input logic [7:0] p, input logic [7:0] m);
    s_we = 1'b1; s_idx = idx; s_pat = p; s_msk = m;
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    exp(0, 0, 0, 0); exp(1, 0, 0, 0); exp(2, 0, 0, 0);
    tick();
  endtask

  task automatic prog(input logic [7:0] p0, p1, p2, p3);
    cfg_set(2'd0, p0, 8'hFF); tick();
    cfg_set(2'd1, p1, 8'hFF); tick();
    cfg_set(2'd2, p2, 8'hFF); tick();
    cfg_set(2'd3, p3, 8'hFF); tick();
  endtask

  // Single-DUT word with expectation for the following cycle.
  task automatic w0(input logic [7:0] d, input int sel, input bit m, input int c, input bit a);
    wd(d); exp(sel, m, c, a); tick();
  endtask

  task automatic idle0(input int sel, input bit m, input int c, input bit a);
    exp(sel, m, c, a); tick();
  endtask

  initial begin
    s_rst = 1'b1; s_clr = 1'b0; s_we = 1'b0; s_vld = 1'b0;
    s_idx = '0; s_pat = '0; s_msk = '0; s_dat = '0;
    @(posedge clk); #1;

    // Reset defaults: pattern 0, mask FF (bit 0 of slot 0 is compared).
    do_reset();
    w0(8'h01, 0, 0, 0, 0); w0(8'h00, 0, 0, 0, 0); w0(8'h00, 0, 0, 0, 0);
    w0(8'h00, 0, 0, 0, 1);
    w0(8'h00, 0, 1, 1, 1);
    idle0(0, 0, 1, 1);

    // Basic frame match.
    do_reset(); prog(8'h55, 8'hAA, 8'h0D, 8'h0A);
    w0(8'h55, 0, 0, 0, 0); w0(8'hAA, 0, 0, 0, 0); w0(8'h0D, 0, 0, 0, 0);
    w0(8'h0A, 0, 1, 1, 1);
    idle0(0, 0, 1, 1);

    // Overlapping vs non-overlapping on a run of identical words.
    do_reset(); prog(8'h41, 8'h41, 8'h41, 8'h41);
    for (int i = 1; i <= 6; i++) begin
      wd(8'h41);
      if (i < 4) begin
        exp(0, 0, 0, 0); exp(1, 0, 0, 0);
      end else begin
        exp(0, 1, i - 3, 1);
        exp(1, (i == 4), 1, 0);
      end
      tick();
    end
    exp(0, 0, 3, 1); exp(1, 0, 1, 0); tick();

    // Valid bubbles between words.
    do_reset(); prog(8'h55, 8'hAA, 8'h0D, 8'h0A);
    w0(8'h55, 0, 0, 0, 0); idle0(0, 0, 0, 0); w0(8'hAA, 0, 0, 0, 0);
    idle0(0, 0, 0, 0); idle0(0, 0, 0, 0);
    w0(8'h0D, 0, 0, 0, 0); w0(8'h0A, 0, 1, 1, 1);
    idle0(0, 0, 1, 1);

    // Don't-care slot 2.
    do_reset(); prog(8'h55, 8'hAA, 8'h0D, 8'h0A);
    cfg_set(2'd2, 8'h0D, 8'h00); tick();
    w0(8'h55, 0, 0, 0, 0); w0(8'hAA, 0, 0, 0, 0); w0(8'h00, 0, 0, 0, 0);
    w0(8'h0A, 0, 1, 1, 1);
    w0(8'h55, 0, 0, 1, 1); w0(8'hAA, 0, 0, 1, 1); w0(8'hFF, 0, 0, 1, 1);
    w0(8'h0A, 0, 1, 2, 1);
    w0(8'h55, 0, 0, 2, 1); w0(8'hAB, 0, 0, 2, 1); w0(8'h00, 0, 0, 2, 1);
    w0(8'h0A, 0, 0, 2, 1);

    // Config write concurrent with the completing word uses the old pattern.
    do_reset(); prog(8'h55, 8'hAA, 8'h0D, 8'h0A);
    w0(8'h55, 0, 0, 0, 0); w0(8'hAA, 0, 0, 0, 0); w0(8'h0D, 0, 0, 0, 0);
    cfg_set(2'd3, 8'h0B, 8'hFF); w0(8'h0A, 0, 1, 1, 1);
    w0(8'h55, 0, 0, 1, 1); w0(8'hAA, 0, 0, 1, 1); w0(8'h0D, 0, 0, 1, 1);
    w0(8'h0A, 0, 0, 1, 1);
    w0(8'h55, 0, 0, 1, 1); w0(8'hAA, 0, 0, 1, 1); w0(8'h0D, 0, 0, 1, 1);
    w0(8'h0B, 0, 1, 2, 1);

    // Narrow counter saturates at 3.
    do_reset(); prog(8'h41, 8'h41, 8'h41, 8'h41);
    for (int i = 1; i <= 8; i++) begin
      wd(8'h41);
      if (i < 4) exp(2, 0, 0, 0);
      else       exp(2, 1, (i - 3 > 3) ? 3 : i - 3, 1);
      tick();
    end

    // Clear mid-window (with a discarded word), then reset mid-stream.
    do_reset(); prog(8'h55, 8'hAA, 8'h0D, 8'h0A);
    w0(8'h55, 0, 0, 0, 0); w0(8'hAA, 0, 0, 0, 0); w0(8'h0D, 0, 0, 0, 0);
    w0(8'h0A, 0, 1, 1, 1);
    w0(8'h55, 0, 0, 1, 1); w0(8'hAA, 0, 0, 1, 1);
    s_clr = 1'b1; w0(8'h0D, 0, 0, 0, 0);
    w0(8'h0D, 0, 0, 0, 0); w0(8'h0A, 0, 0, 0, 0);
    w0(8'h55, 0, 0, 0, 0); w0(8'hAA, 0, 0, 0, 1); w0(8'h0D, 0, 0, 0, 1);
    w0(8'h0A, 0, 1, 1, 1);
    s_vld = 1'b1; s_dat = 8'h55; do_reset();
    w0(8'h00, 0, 0, 0, 0); w0(8'h00, 0, 0, 0, 0); w0(8'h00, 0, 0, 0, 0);
    w0(8'h00, 0, 1, 1, 1);

    tick(); tick();
    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
